// File: rtl/load_store_unit.sv
// Load/store unit: single-request memory initiator with sub-word extraction and
// read-modify-write byte/halfword stores. Optional trap build: LSU_MISALIGN_TRAP_EN.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        fault,
`endif
    output logic [31:0] adr,
    output logic [31:0] writedata,
    output logic        MR,
    output logic        MW,
    input  logic [31:0] readdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t      state, state_nxt;
    logic        cap_we;
    logic [1:0]  cap_size;
    logic        cap_sext;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [31:0] rd_word;

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] sz,
                                            input logic [1:0] a, input logic sx);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = word[{a, 3'b000} +: 8];
        h = word[{a[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   extract = sx ? {{24{b[7]}}, b} : {24'b0, b};
            2'b01:   extract = sx ? {{16{h[15]}}, h} : {16'b0, h};
            default: extract = word;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] wd,
                                          input logic [1:0] sz, input logic [1:0] a);
        logic [31:0] m;
        m = word;
        case (sz)
            2'b00:   m[{a, 3'b000} +: 8]     = wd[7:0];
            2'b01:   m[{a[1], 4'b0000} +: 16] = wd[15:0];
            default: m = wd;
        endcase
        return m;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
        return ((sz == 2'b01) && a[0]) || (sz[1] && (a != 2'b00));
    endfunction

    logic fault_r;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rdata <= 32'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            fault_r <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == RD && !cap_we)
                rdata <= extract(readdata, cap_size, cap_addr[1:0], cap_sext);
`ifdef LSU_MISALIGN_TRAP_EN
            if (state == IDLE && req)
                fault_r <= misaligned(size, addr[1:0]);
`endif
        end
    end

    // Request and read-word holding registers need no reset: outputs are gated by state.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            cap_we    <= we;
            cap_size  <= size;
            cap_sext  <= sign_ext;
            cap_addr  <= addr;
            cap_wdata <= wdata;
        end
        if (state == RD)
            rd_word <= readdata;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        MR        = 1'b0;
        MW        = 1'b0;
        adr       = 32'b0;
        writedata = 32'b0;
        case (state)
            IDLE: begin
                if (req) begin
`ifdef LSU_MISALIGN_TRAP_EN
                    if (misaligned(size, addr[1:0]))
                        state_nxt = DONE;
                    else
`endif
                    if (we && size[1])
                        state_nxt = WR;
                    else
                        state_nxt = RD;
                end
            end
            RD: begin
                MR        = 1'b1;
                adr       = {cap_addr[31:2], 2'b00};
                state_nxt = cap_we ? WR : DONE;
            end
            WR: begin
                MW        = 1'b1;
                adr       = {cap_addr[31:2], 2'b00};
                // Word stores skip RD, so rd_word is only meaningful for sub-word merges.
                writedata = cap_size[1] ? cap_wdata
                                        : merge(rd_word, cap_wdata, cap_size, cap_addr[1:0]);
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign fault = (state == DONE) && fault_r;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus reset and back-pressure sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        busy, done, MR, MW;
    logic [31:0] rdata, adr, writedata, readdata;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        fault;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
`ifdef LSU_MISALIGN_TRAP_EN
        .fault(fault),
`endif
        .adr(adr), .writedata(writedata), .MR(MR), .MW(MW), .readdata(readdata)
    );

    // Word-addressed memory model; writes to address 0 are dropped.
    logic [31:0] mem [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx;
    logic [31:0] pl_data;

    assign readdata = MR ? mem[adr[7:2]] : 32'h5A5A5A5A;

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_idx] <= pl_data;
        else if (MW && adr != 32'b0)
            mem[adr[7:2]] <= writedata;
    end

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = a[7:2]; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        string       nm;
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;      // load: rdata; store: writedata during MW
        logic [31:0] exp_mem;  // store: memory word afterwards
        int          lat;
        int          mr;
        int          mw;
        logic        flt;
    } vec_t;

    task automatic run(input vec_t v);
        int   n, mrc, mwc;
        logic seen;
        @(negedge clk);
        we = v.we; size = v.size; sign_ext = v.sext; addr = v.addr; wdata = v.wdata; req = 1'b1;
        n = 0; mrc = 0; mwc = 0; seen = 1'b0;
        while (!seen && n < 8) begin
            @(negedge clk);
            n++;
            if (!busy) check({v.nm, "_busy"}, 32'(busy), 32'd1);
            if (MR && MW) check({v.nm, "_mrmw"}, 32'(MR & MW), 32'd0);
            if (MR) begin
                mrc++;
                check({v.nm, "_rdadr"}, adr, {v.addr[31:2], 2'b00});
                check({v.nm, "_rdwd"}, writedata, 32'd0);
            end
            if (MW) begin
                mwc++;
                check({v.nm, "_wradr"}, adr, {v.addr[31:2], 2'b00});
                check({v.nm, "_wrwd"}, writedata, v.exp);
            end
            if (done) begin
                seen = 1'b1;
                check({v.nm, "_doneadr"}, adr, 32'd0);
                check({v.nm, "_donewd"}, writedata, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
                check({v.nm, "_fault"}, 32'(fault), 32'(v.flt));
`endif
            end
        end
        req = 1'b0;
        check({v.nm, "_lat"}, 32'(n), 32'(v.lat));
        check({v.nm, "_mrcnt"}, 32'(mrc), 32'(v.mr));
        check({v.nm, "_mwcnt"}, 32'(mwc), 32'(v.mw));
        if (!v.we) check({v.nm, "_rdata"}, rdata, v.exp);
        else       check({v.nm, "_mem"}, mem[v.addr[7:2]], v.exp_mem);
    endtask

    vec_t vecs [14];
    int   mr_seen, mw_seen;

    initial begin
        //          name      we size   sx addr     wdata          exp            exp_mem        lat mr mw flt
        vecs[0]  = '{"ldw",   0, 2'b10, 0, 32'h10, 32'h0,         32'h8899AABB, 32'h0,         2, 1, 0, 0};
        vecs[1]  = '{"ldbs",  0, 2'b00, 1, 32'h13, 32'h0,         32'hFFFFFF88, 32'h0,         2, 1, 0, 0};
        vecs[2]  = '{"ldbz",  0, 2'b00, 0, 32'h13, 32'h0,         32'h00000088, 32'h0,         2, 1, 0, 0};
        vecs[3]  = '{"ldhs",  0, 2'b01, 1, 32'h10, 32'h0,         32'hFFFFAABB, 32'h0,         2, 1, 0, 0};
        vecs[4]  = '{"ldhz",  0, 2'b01, 0, 32'h12, 32'h0,         32'h00008899, 32'h0,         2, 1, 0, 0};
        vecs[5]  = '{"ldb0",  0, 2'b00, 1, 32'h10, 32'h0,         32'hFFFFFFBB, 32'h0,         2, 1, 0, 0};
        vecs[6]  = '{"stb",   1, 2'b00, 0, 32'h21, 32'hEE,        32'h1122EE44, 32'h1122EE44, 3, 1, 1, 0};
        vecs[7]  = '{"stw",   1, 2'b10, 0, 32'h24, 32'hDEADBEEF,  32'hDEADBEEF, 32'hDEADBEEF, 2, 0, 1, 0};
        vecs[8]  = '{"ldback",0, 2'b10, 0, 32'h24, 32'h0,         32'hDEADBEEF, 32'h0,         2, 1, 0, 0};
        vecs[9]  = '{"sth",   1, 2'b01, 0, 32'h22, 32'h1234CAFE,  32'hCAFEEE44, 32'hCAFEEE44, 3, 1, 1, 0};
        vecs[10] = '{"stb3",  1, 2'b00, 0, 32'h23, 32'hFFFFFF5A,  32'h5AFEEE44, 32'h5AFEEE44, 3, 1, 1, 0};
        vecs[11] = '{"ld11",  0, 2'b11, 0, 32'h24, 32'h0,         32'hDEADBEEF, 32'h0,         2, 1, 0, 0};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[12] = '{"ldmis", 0, 2'b10, 0, 32'h22, 32'h0,         32'hDEADBEEF, 32'h0,         1, 0, 0, 1};
`else
        vecs[12] = '{"ldmis", 0, 2'b10, 0, 32'h22, 32'h0,         32'h5AFEEE44, 32'h0,         2, 1, 0, 0};
`endif
        vecs[13] = '{"st0",   1, 2'b10, 0, 32'h00, 32'h00000001,  32'h00000001, 32'h0,         2, 0, 1, 0};

        req = 0; we = 0; size = 0; sign_ext = 0; addr = 0; wdata = 0;
        rst_n = 1'b0;
        poke(32'h00, 32'h0);
        poke(32'h10, 32'h8899AABB);
        poke(32'h20, 32'h11223344);
        poke(32'h24, 32'h0);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_mrmw", 32'({MR, MW}), 0);
        check("rst_adr", adr, 0);
        check("rst_wd", writedata, 0);
        check("rst_rdata", rdata, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("rst_fault", 32'(fault), 0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run(vecs[i]);

        // Back-pressure: request inputs change while busy; the captured load must win.
        @(negedge clk);
        we = 0; size = 2'b10; addr = 32'h10; req = 1'b1;
        mr_seen = 0; mw_seen = 0;
        @(negedge clk);
        we = 1; addr = 32'h24; wdata = 32'h0BADF00D;
        for (int n = 0; n < 8 && !done; n++) begin
            if (MR) mr_seen++;
            if (MW) mw_seen++;
            @(negedge clk);
        end
        check("bp_done", 32'(done), 1);
        req = 1'b0;
        check("bp_rdata", rdata, 32'h8899AABB);
        check("bp_mr", 32'(mr_seen), 1);
        check("bp_mw", 32'(mw_seen), 0);
        @(negedge clk);
        check("bp_idle", 32'({busy, MR, MW}), 0);
        check("bp_mem", mem[9], 32'hDEADBEEF);

        // Reset during the RD cycle of a halfword store.
        @(negedge clk);
        we = 1; size = 2'b01; addr = 32'h20; wdata = 32'h7777; req = 1'b1;
        @(negedge clk);
        check("rstrd_mr", 32'(MR), 1);
        #1 rst_n = 1'b0;
        #1;
        check("rstrd_strobes", 32'({MR, MW}), 0);
        check("rstrd_busy", 32'(busy), 0);
        check("rstrd_adr", adr, 0);
        req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rstrd_mem", mem[8], 32'h5AFEEE44);
        check("rstrd_rdata", rdata, 0);
        check("rstrd_idle", 32'({busy, done, MW}), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
